// File: rtl/ahb_ram_responder_if.sv
// AHB-Lite bundle between a protected hardisc bus master and the RAM responder,
// carrying address/control parity and SEC-DED checksums alongside the usual signals.
interface ahb_ram_responder_if;
  logic        s_hsel_i;
  logic [31:0] s_haddr_i;
  logic [1:0]  s_htrans_i;
  logic        s_hwrite_i;
  logic [2:0]  s_hsize_i;
  logic [31:0] s_hwdata_i;
  logic [6:0]  s_hwchecksum_i;
  logic [5:0]  s_hparity_i;
  logic        s_hready_i;
  logic [31:0] s_hrdata_o;
  logic [6:0]  s_hrchecksum_o;
  logic        s_hreadyout_o;
  logic        s_hresp_o;
  logic        s_perr_o;
  logic        s_cerr_o;

  modport slave (
    input  s_hsel_i, s_haddr_i, s_htrans_i, s_hwrite_i, s_hsize_i, s_hwdata_i,
           s_hwchecksum_i, s_hparity_i, s_hready_i,
    output s_hrdata_o, s_hrchecksum_o, s_hreadyout_o, s_hresp_o, s_perr_o, s_cerr_o
  );

  modport master (
    output s_hsel_i, s_haddr_i, s_htrans_i, s_hwrite_i, s_hsize_i, s_hwdata_i,
           s_hwchecksum_i, s_hparity_i, s_hready_i,
    input  s_hrdata_o, s_hrchecksum_o, s_hreadyout_o, s_hresp_o, s_perr_o, s_cerr_o
  );
endinterface

// File: rtl/ahb_ram_responder.sv
// Word-addressed AHB-Lite RAM slave: checks address parity and write checksums,
// returns checksummed read data, inserts wait states and issues two-cycle errors.
module ahb_ram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 4096,
  parameter int          WAIT_STATES = 0
) (
  input logic                s_clk_i,
  input logic                s_resetn_i,
  ahb_ram_responder_if.slave bus
);
  localparam int IDXW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] ERR1 = 2'd2;
  localparam logic [1:0] ERR2 = 2'd3;

  // Shared (39,32) SEC-DED: Hamming bits over codeword positions 1..38, plus overall parity.
  function automatic logic [6:0] secdedEncode(input logic [31:0] d);
    logic [6:0] c;
    int         j;
    c = '0;
    j = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int i = 0; i < 6; i++) begin
          if (p[i]) c[i] = c[i] ^ d[j];
        end
        j++;
      end
    end
    c[6] = ^{d, c[5:0]};
    return c;
  endfunction

  logic [31:0]     mem [MEM_WORDS];
  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [3:0]      lanes_q, lanes_d;
  logic            write_q, write_d;
  logic [31:0]     hrdata_q, hrdata_d;
  logic [6:0]      hrchk_q, hrchk_d;
  logic            perr_q, perr_d;
  logic            cerr_q, cerr_d;

  logic            readyOut, accept, dataDone, chkOk, commit, addrErr;
  logic [5:0]      parExp;
  logic [31:0]     offset;
  logic [IDXW-1:0] aIdx;
  logic [3:0]      aLanes;
  logic [31:0]     rdWord;

  always_comb begin
    readyOut = (state_q == IDLE) || (state_q == ERR2) || ((state_q == DATA) && (cnt_q == 4'd0));
    accept   = readyOut && bus.s_hready_i && bus.s_hsel_i && bus.s_htrans_i[1];
    dataDone = (state_q == DATA) && (cnt_q == 4'd0);
    chkOk    = (secdedEncode(bus.s_hwdata_i) == bus.s_hwchecksum_i);
    commit   = dataDone && write_q && chkOk;

    parExp = {^bus.s_hsize_i, ^{bus.s_htrans_i, bus.s_hwrite_i},
              ^bus.s_haddr_i[31:24], ^bus.s_haddr_i[23:16],
              ^bus.s_haddr_i[15:8], ^bus.s_haddr_i[7:0]};
    // Unsigned subtraction makes addresses below the window wrap high and fail the range check.
    offset  = bus.s_haddr_i - BASE_ADDR;
    aIdx    = offset[IDXW+1:2];
    addrErr = (parExp != bus.s_hparity_i) || (bus.s_hsize_i > 3'd2)
           || ((bus.s_hsize_i == 3'd1) && bus.s_haddr_i[0])
           || ((bus.s_hsize_i == 3'd2) && (bus.s_haddr_i[1:0] != 2'b00))
           || ((offset >> 2) >= 32'(MEM_WORDS));

    case (bus.s_hsize_i)
      3'd0:    aLanes = 4'b0001 << bus.s_haddr_i[1:0];
      3'd1:    aLanes = bus.s_haddr_i[1] ? 4'b1100 : 4'b0011;
      default: aLanes = 4'b1111;
    endcase

    // Forward a write committing this cycle so a back-to-back read sees the new bytes.
    rdWord = mem[aIdx];
    for (int b = 0; b < 4; b++) begin
      if (commit && lanes_q[b] && (idx_q == aIdx)) rdWord[8*b +: 8] = bus.s_hwdata_i[8*b +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lanes_d  = lanes_q;
    write_d  = write_q;
    hrdata_d = hrdata_q;
    hrchk_d  = hrchk_q;
    perr_d   = 1'b0;
    cerr_d   = dataDone && write_q && !chkOk;

    case (state_q)
      DATA:    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
               else               state_d = IDLE;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      perr_d = (parExp != bus.s_hparity_i);
      if (addrErr) begin
        state_d = ERR1;
      end else begin
        state_d = DATA;
        cnt_d   = 4'(WAIT_STATES);
        idx_d   = aIdx;
        lanes_d = aLanes;
        write_d = bus.s_hwrite_i;
        if (!bus.s_hwrite_i) begin
          hrdata_d = rdWord;
          hrchk_d  = secdedEncode(rdWord);
        end
      end
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      lanes_q  <= '0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
      hrchk_q  <= '0;
      perr_q   <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lanes_q  <= lanes_d;
      write_q  <= write_d;
      hrdata_q <= hrdata_d;
      hrchk_q  <= hrchk_d;
      perr_q   <= perr_d;
      cerr_q   <= cerr_d;
    end
  end

  // RAM is never reset; a reset edge suppresses any commit in flight.
  always_ff @(posedge s_clk_i) begin
    if (s_resetn_i && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes_q[b]) mem[idx_q][8*b +: 8] <= bus.s_hwdata_i[8*b +: 8];
      end
    end
  end

  assign bus.s_hreadyout_o  = readyOut;
  assign bus.s_hresp_o      = (state_q == ERR1) || (state_q == ERR2);
  assign bus.s_hrdata_o     = hrdata_q;
  assign bus.s_hrchecksum_o = hrchk_q;
  assign bus.s_perr_o       = perr_q;
  assign bus.s_cerr_o       = cerr_q;
endmodule
